// File: rtl/vm_credit_ctrl.sv
// Credit controller for the vending machine: sequences the external adder/subtractor,
// keeps the running credit and runs the change-dispense handshake.
module vm_credit_ctrl #(
  parameter int   WIDTH      = 5,
  parameter logic BORROW_LVL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [WIDTH-1:0] coin_value,
  input  logic             select_valid,
  input  logic [WIDTH-1:0] price,
  input  logic             cancel,
  input  logic             change_ack,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry_borrow,
  output logic [WIDTH-1:0] credit,
  output logic             busy,
  output logic             vend,
  output logic             coin_reject,
  output logic             insufficient,
  output logic             change_valid,
  output logic [WIDTH-1:0] change_amount
);

  typedef enum logic [1:0] {IDLE, ADD, SUB, CHANGE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] alu_a_nxt, alu_b_nxt, credit_nxt, change_amount_nxt;
  logic             alu_sub_nxt, vend_nxt, coin_reject_nxt, insufficient_nxt, change_valid_nxt;
  logic             borrowed, sub_ok;

  assign borrowed = (alu_carry_borrow == BORROW_LVL);
  assign sub_ok   = !borrowed;

  // Every output is a flop; the state register carries them alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_sub       <= 1'b0;
      credit        <= '0;
      busy          <= 1'b0;
      vend          <= 1'b0;
      coin_reject   <= 1'b0;
      insufficient  <= 1'b0;
      change_valid  <= 1'b0;
      change_amount <= '0;
    end else begin
      state         <= state_nxt;
      alu_a         <= alu_a_nxt;
      alu_b         <= alu_b_nxt;
      alu_sub       <= alu_sub_nxt;
      credit        <= credit_nxt;
      busy          <= (state_nxt != IDLE);
      vend          <= vend_nxt;
      coin_reject   <= coin_reject_nxt;
      insufficient  <= insufficient_nxt;
      change_valid  <= change_valid_nxt;
      change_amount <= change_amount_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cancel) begin
          if (credit != '0) state_nxt = CHANGE;
        end else if (select_valid) begin
          state_nxt = SUB;
        end else if (coin_valid) begin
          state_nxt = ADD;
        end
      end
      ADD:    state_nxt = IDLE;
      SUB: begin
        if (sub_ok && (alu_result != '0)) state_nxt = CHANGE;
        else                              state_nxt = IDLE;
      end
      CHANGE: if (change_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A cancel with zero credit still swallows any coin or select in the same cycle.
  always_comb begin
    alu_a_nxt         = alu_a;
    alu_b_nxt         = alu_b;
    alu_sub_nxt       = alu_sub;
    credit_nxt        = credit;
    change_valid_nxt  = change_valid;
    change_amount_nxt = change_amount;
    vend_nxt          = 1'b0;
    coin_reject_nxt   = 1'b0;
    insufficient_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (cancel) begin
          if (credit != '0) begin
            change_amount_nxt = credit;
            change_valid_nxt  = 1'b1;
          end
        end else if (select_valid) begin
          alu_a_nxt   = credit;
          alu_b_nxt   = price;
          alu_sub_nxt = 1'b1;
        end else if (coin_valid) begin
          alu_a_nxt   = credit;
          alu_b_nxt   = coin_value;
          alu_sub_nxt = 1'b0;
        end
      end
      ADD: begin
        if (alu_carry_borrow) coin_reject_nxt = 1'b1;
        else                  credit_nxt      = alu_result;
      end
      SUB: begin
        if (borrowed) begin
          insufficient_nxt = 1'b1;
        end else begin
          vend_nxt   = 1'b1;
          credit_nxt = alu_result;
          if (alu_result != '0) begin
            change_amount_nxt = alu_result;
            change_valid_nxt  = 1'b1;
          end
        end
      end
      CHANGE: begin
        if (change_ack) begin
          credit_nxt        = '0;
          change_valid_nxt  = 1'b0;
          change_amount_nxt = '0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vm_credit_ctrl.sv
// Scoreboard bench for vm_credit_ctrl: a plain-arithmetic credit model predicts each
// completed operation, a negedge monitor pops and compares when the DUT reports one.
module tb_vm_credit_ctrl;

  localparam int   WIDTH      = 5;
  localparam int   MAXC       = (1 << WIDTH) - 1;
  localparam logic BORROW_LVL = 1'b1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             coin_valid, select_valid, cancel, change_ack;
  logic [WIDTH-1:0] coin_value, price;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result, credit, change_amount;
  logic             alu_sub, alu_carry_borrow, busy, vend, coin_reject, insufficient, change_valid;

  typedef struct packed {
    logic             vend;
    logic             rej;
    logic             ins;
    logic             cv;
    logic [WIDTH-1:0] amt;
    logic [WIDTH-1:0] credit;
    logic             busy;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   credit_m = 0;
  bit   in_change = 1'b0;
  logic prev_busy = 1'b0, prev_cv = 1'b0;

  vm_credit_ctrl #(.WIDTH(WIDTH), .BORROW_LVL(BORROW_LVL)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value),
    .select_valid(select_valid), .price(price),
    .cancel(cancel), .change_ack(change_ack),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub),
    .alu_result(alu_result), .alu_carry_borrow(alu_carry_borrow),
    .credit(credit), .busy(busy), .vend(vend), .coin_reject(coin_reject),
    .insufficient(insufficient), .change_valid(change_valid), .change_amount(change_amount)
  );

  always #5 clk = ~clk;

  // Combinational adder/subtractor the controller drives.
  always_comb begin
    if (alu_sub) begin
      alu_result       = alu_a - alu_b;
      alu_carry_borrow = (alu_a < alu_b) ? BORROW_LVL : ~BORROW_LVL;
    end else begin
      {alu_carry_borrow, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  function automatic exp_t mkExp(bit v, bit r, bit i, bit c, int amt, int cr, bit b);
    exp_t e;
    e.vend = v; e.rej = r; e.ins = i; e.cv = c;
    e.amt = amt[WIDTH-1:0]; e.credit = cr[WIDTH-1:0]; e.busy = b;
    return e;
  endfunction

  function automatic logic [31:0] allOutputs();
    return {6'd0, alu_a, alu_b, alu_sub, credit, busy, vend, coin_reject, insufficient,
            change_valid, change_amount};
  endfunction

  // Monitor: an operation is reported by a pulse, change_valid rising, or busy falling.
  initial begin
    exp_t got, want;
    bit   trig;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_busy = 1'b0;
        prev_cv   = 1'b0;
      end else begin
        trig = vend | coin_reject | insufficient | (change_valid & ~prev_cv) | (prev_busy & ~busy);
        if (trig) begin
          got = '{vend, coin_reject, insufficient, change_valid, change_amount, credit, busy};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_event actual=%h required=none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("[TB] FAIL event actual vend=%0d rej=%0d ins=%0d cv=%0d amt=%0d credit=%0d busy=%0d required vend=%0d rej=%0d ins=%0d cv=%0d amt=%0d credit=%0d busy=%0d",
                       got.vend, got.rej, got.ins, got.cv, got.amt, got.credit, got.busy,
                       want.vend, want.rej, want.ins, want.cv, want.amt, want.credit, want.busy);
            end
          end
        end
        prev_busy = busy;
        prev_cv   = change_valid;
      end
    end
  end

  task automatic applyStimulus(input bit do_coin, input bit do_sel, input bit do_cancel,
                               input int cv, input int pv);
    int old;
    bit alu_op;
    old    = credit_m;
    alu_op = 1'b0;
    @(negedge clk);
    coin_valid   = do_coin;
    coin_value   = cv[WIDTH-1:0];
    select_valid = do_sel;
    price        = pv[WIDTH-1:0];
    cancel       = do_cancel;
    if (do_cancel) begin
      if (credit_m != 0) begin
        exp_q.push_back(mkExp(0, 0, 0, 1, credit_m, credit_m, 1));
        in_change = 1'b1;
      end
    end else if (do_sel) begin
      alu_op = 1'b1;
      if (pv > credit_m) begin
        exp_q.push_back(mkExp(0, 0, 1, 0, 0, credit_m, 0));
      end else begin
        credit_m = credit_m - pv;
        in_change = (credit_m != 0);
        exp_q.push_back(mkExp(1, 0, 0, in_change, credit_m, credit_m, in_change));
      end
    end else if (do_coin) begin
      alu_op = 1'b1;
      if (credit_m + cv > MAXC) exp_q.push_back(mkExp(0, 1, 0, 0, 0, credit_m, 0));
      else begin
        credit_m = credit_m + cv;
        exp_q.push_back(mkExp(0, 0, 0, 0, 0, credit_m, 0));
      end
    end
    @(negedge clk);
    coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0;
    if (alu_op) begin
      checkOutput("alu_a", 32'(alu_a), 32'(old));
      checkOutput("alu_b", 32'(alu_b), do_sel ? 32'(pv) : 32'(cv));
      checkOutput("alu_sub", 32'(alu_sub), 32'(do_sel));
      checkOutput("busy_op", 32'(busy), 32'd1);
      @(negedge clk);
    end else if (!in_change) begin
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_credit", 32'(credit), 32'(credit_m));
    end
  endtask

  task automatic applyAck(input int hold);
    int amt;
    amt = credit_m;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      change_ack   = 1'b0;
      coin_valid   = 1'($urandom_range(0, 1));
      select_valid = 1'($urandom_range(0, 1));
      cancel       = 1'($urandom_range(0, 1));
      coin_value   = WIDTH'($urandom_range(0, MAXC));
      price        = WIDTH'($urandom_range(0, MAXC));
      checkOutput("hold_cv", 32'(change_valid), 32'd1);
      checkOutput("hold_amt", 32'(change_amount), 32'(amt));
      checkOutput("hold_credit", 32'(credit), 32'(amt));
    end
    @(negedge clk);
    coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0;
    change_ack = 1'b1;
    credit_m   = 0;
    in_change  = 1'b0;
    exp_q.push_back(mkExp(0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    change_ack = 1'b0;
  endtask

  task automatic idleAck();
    @(negedge clk);
    change_ack = 1'b1;
    @(negedge clk);
    change_ack = 1'b0;
    checkOutput("idle_ack_busy", 32'(busy), 32'd0);
    checkOutput("idle_ack_credit", 32'(credit), 32'(credit_m));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    rst_n = 1'b0;
    coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0; change_ack = 1'b0;
    coin_value = '0; price = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    rst_n = 1'b1;

    applyStimulus(1, 0, 0, 10, 0);
    applyStimulus(1, 0, 0, 5, 0);
    checkOutput("credit_15", 32'(credit), 32'd15);
    applyStimulus(0, 1, 0, 0, 5);
    applyAck(0);
    checkOutput("after_ack_busy", 32'(busy), 32'd0);

    applyStimulus(1, 0, 0, 20, 0);
    applyStimulus(1, 0, 0, 10, 0);
    applyStimulus(1, 0, 0, 5, 0);
    checkOutput("credit_30", 32'(credit), 32'd30);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 1, 0);
    applyStimulus(0, 0, 1, 0, 0);
    applyAck(1);

    applyStimulus(1, 0, 0, 3, 0);
    applyStimulus(0, 1, 0, 0, 7);
    applyStimulus(0, 0, 1, 0, 0);
    applyAck(0);

    applyStimulus(1, 0, 0, 8, 0);
    applyStimulus(0, 1, 0, 0, 8);
    checkOutput("exact_cv", 32'(change_valid), 32'd0);

    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    idleAck();

    applyStimulus(1, 0, 0, 12, 0);
    applyStimulus(1, 0, 1, 5, 0);
    applyAck(5);

    applyStimulus(1, 0, 0, 12, 0);
    applyStimulus(0, 0, 1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_outputs", allOutputs(), 32'd0);
    checkOutput("queue_at_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    credit_m = 0; in_change = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_outputs", allOutputs(), 32'd0);

    for (int n = 0; n < 300; n++) begin
      if (in_change) begin
        applyAck($urandom_range(0, 3));
      end else begin
        r = $urandom_range(0, 9);
        case (r)
          0, 1, 2, 3: applyStimulus(1, 0, 0, ($urandom_range(0, 3) == 0) ? MAXC : $urandom_range(0, 12), 0);
          4, 5, 6:    applyStimulus(0, 1, 0, 0, ($urandom_range(0, 1) == 1) ? $urandom_range(0, credit_m)
                                                                               : $urandom_range(0, MAXC));
          7:          applyStimulus(0, 0, 1, 0, 0);
          8:          applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    $urandom_range(0, MAXC), $urandom_range(0, MAXC));
          default:    idleAck();
        endcase
      end
    end
    if (in_change) applyAck(0);
    repeat (2) @(negedge clk);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("final_credit", 32'(credit), 32'(credit_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
